// File: rtl/regfile_write_arbiter.sv
// Write-port controller for the 32x32 integer register file: wb/aux arbitration with aux starvation bound.
// Optional post-reset clear sweep of x1..x31 is built when RF_ARB_CLEAR_EN is defined.
module regfile_write_arbiter #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_wb_valid,
   input  logic [4:0]  i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic        o_wb_ready,
   input  logic        i_aux_valid,
   input  logic [4:0]  i_aux_addr,
   input  logic [31:0] i_aux_data,
   output logic        o_aux_ready,
   output logic [31:0] o_rf_we,
   output logic [4:0]  o_rf_waddr,
   output logic [31:0] o_rf_wdata,
   output logic        o_busy
);

   typedef enum logic {ST_CLEAR = 1'b0, ST_ARB = 1'b1} state_e;

   localparam logic [3:0] MAX_W = MAX_WAIT[3:0];

`ifdef RF_ARB_CLEAR_EN
   localparam state_e RST_STATE = ST_CLEAR;
   logic [4:0] cnt_q, cnt_d;
`else
   localparam state_e RST_STATE = ST_ARB;
`endif

   state_e      state_q, state_d;
   logic [3:0]  aux_wait_q, aux_wait_d;
   logic [31:0] we_q, we_d;
   logic [4:0]  waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;

   logic arb_s, force_s, wb_rdy_s, aux_rdy_s, wb_hs_s, aux_hs_s;

   function automatic logic [31:0] onehot_we(input logic [4:0] addr);
      logic [31:0] we;
      we = 32'd1 << addr;
      if (addr == 5'd0) begin
         we = 32'd0;
      end else begin
         we = we;
      end
      return we;
   endfunction

   // Readies are held low while reset is asserted, even in a build with no sweep state.
   assign arb_s     = (state_q == ST_ARB) && i_rst_n;
   assign force_s   = (aux_wait_q == MAX_W) && i_aux_valid;
   assign wb_rdy_s  = arb_s && !force_s;
   assign aux_rdy_s = arb_s && (force_s || !i_wb_valid);
   assign wb_hs_s   = i_wb_valid && wb_rdy_s;
   assign aux_hs_s  = i_aux_valid && aux_rdy_s;

   assign o_wb_ready  = wb_rdy_s;
   assign o_aux_ready = aux_rdy_s;
   assign o_rf_we     = we_q;
   assign o_rf_waddr  = waddr_q;
   assign o_rf_wdata  = wdata_q;
`ifdef RF_ARB_CLEAR_EN
   assign o_busy = (state_q == ST_CLEAR);
`else
   assign o_busy = 1'b0;
`endif

   // Next-state: sweep sequencing, grant selection, write-port load and aux wait counter.
   always_comb begin
      state_d    = state_q;
      aux_wait_d = aux_wait_q;
      we_d       = 32'd0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
`ifdef RF_ARB_CLEAR_EN
      cnt_d      = cnt_q;
`endif
      case (state_q)
`ifdef RF_ARB_CLEAR_EN
         ST_CLEAR: begin
            we_d       = onehot_we(cnt_q);
            waddr_d    = cnt_q;
            wdata_d    = 32'd0;
            aux_wait_d = 4'd0;
            if (cnt_q == 5'd31) begin
               state_d = ST_ARB;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
`endif
         ST_ARB: begin
            if (wb_hs_s) begin
               we_d    = onehot_we(i_wb_addr);
               waddr_d = i_wb_addr;
               wdata_d = i_wb_data;
            end else if (aux_hs_s) begin
               we_d    = onehot_we(i_aux_addr);
               waddr_d = i_aux_addr;
               wdata_d = i_aux_data;
            end else begin
               we_d = 32'd0;
            end
            // Wait counts only cycles in which aux is actually blocked; saturates at the force level.
            if (!i_aux_valid || aux_hs_s) begin
               aux_wait_d = 4'd0;
            end else if (aux_wait_q < MAX_W) begin
               aux_wait_d = aux_wait_q + 4'd1;
            end else begin
               aux_wait_d = aux_wait_q;
            end
         end
         default: begin
            state_d = RST_STATE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= RST_STATE;
         aux_wait_q <= 4'd0;
         we_q       <= 32'd0;
         waddr_q    <= 5'd0;
         wdata_q    <= 32'd0;
`ifdef RF_ARB_CLEAR_EN
         cnt_q      <= 5'd1;
`endif
      end else begin
         state_q    <= state_d;
         aux_wait_q <= aux_wait_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
`ifdef RF_ARB_CLEAR_EN
         cnt_q      <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (MAX_WAIT = 4).
// Sweep checks are included when RF_ARB_CLEAR_EN is defined.
module tb_regfile_write_arbiter;

   logic        clk_s = 1'b0;
   logic        rst_n_s;
   logic        wb_valid_s;
   logic [4:0]  wb_addr_s;
   logic [31:0] wb_data_s;
   logic        wb_ready_s;
   logic        aux_valid_s;
   logic [4:0]  aux_addr_s;
   logic [31:0] aux_data_s;
   logic        aux_ready_s;
   logic [31:0] rf_we_s;
   logic [4:0]  rf_waddr_s;
   logic [31:0] rf_wdata_s;
   logic        busy_s;

   int n_checks = 0;
   int n_pass   = 0;

   regfile_write_arbiter #(.MAX_WAIT(4)) dut (
      .i_clk       (clk_s),
      .i_rst_n     (rst_n_s),
      .i_wb_valid  (wb_valid_s),
      .i_wb_addr   (wb_addr_s),
      .i_wb_data   (wb_data_s),
      .o_wb_ready  (wb_ready_s),
      .i_aux_valid (aux_valid_s),
      .i_aux_addr  (aux_addr_s),
      .i_aux_data  (aux_data_s),
      .o_aux_ready (aux_ready_s),
      .o_rf_we     (rf_we_s),
      .o_rf_waddr  (rf_waddr_s),
      .o_rf_wdata  (rf_wdata_s),
      .o_busy      (busy_s)
   );

   always #5 clk_s = ~clk_s;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_we"},    rf_we_s,     32'd0);
      check_eq({tag, "_waddr"}, {27'd0, rf_waddr_s}, 32'd0);
      check_eq({tag, "_wdata"}, rf_wdata_s,  32'd0);
      check_eq({tag, "_wbrdy"}, {31'd0, wb_ready_s},  32'd0);
      check_eq({tag, "_auxrdy"},{31'd0, aux_ready_s}, 32'd0);
   endtask

`ifdef RF_ARB_CLEAR_EN
   task automatic run_sweep(input int ncyc);
      logic [31:0] exp_we;
      for (int k = 1; k <= ncyc; k++) begin
         check_eq("sweep_busy", {31'd0, busy_s}, 32'd1);
         check_eq("sweep_wbrdy", {31'd0, wb_ready_s}, 32'd0);
         @(posedge clk_s); #1;
         exp_we = 32'd1 << k;
         check_eq("sweep_we", rf_we_s, exp_we);
         check_eq("sweep_waddr", {27'd0, rf_waddr_s}, k[31:0]);
         check_eq("sweep_wdata", rf_wdata_s, 32'd0);
      end
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_busy;
`ifdef RF_ARB_CLEAR_EN
      exp_busy = 32'd1;
`else
      exp_busy = 32'd0;
`endif
      rst_n_s     = 1'b0;
      wb_valid_s  = 1'b1;
      wb_addr_s   = 5'd2;
      wb_data_s   = 32'h1111_1111;
      aux_valid_s = 1'b0;
      aux_addr_s  = 5'd0;
      aux_data_s  = 32'd0;
      #23;
      check_zero_outputs("reset");
      check_eq("reset_busy", {31'd0, busy_s}, exp_busy);
      wb_valid_s = 1'b0;

      @(negedge clk_s);
      rst_n_s = 1'b1;
`ifdef RF_ARB_CLEAR_EN
      run_sweep(31);
`endif
      check_eq("post_busy", {31'd0, busy_s}, 32'd0);

      // wb write to x31 at the first opportunity
      wb_valid_s = 1'b1; wb_addr_s = 5'd31; wb_data_s = 32'hA5A5_5A5A;
      #1;
      check_eq("x31_wbrdy", {31'd0, wb_ready_s}, 32'd1);
      @(posedge clk_s); #1;
      wb_valid_s = 1'b0;
      check_eq("x31_we",    rf_we_s, 32'h8000_0000);
      check_eq("x31_waddr", {27'd0, rf_waddr_s}, 32'd31);
      check_eq("x31_wdata", rf_wdata_s, 32'hA5A5_5A5A);

      // wb only, x5
      wb_valid_s = 1'b1; wb_addr_s = 5'd5; wb_data_s = 32'hDEAD_BEEF;
      #1;
      check_eq("wb5_wbrdy",  {31'd0, wb_ready_s},  32'd1);
      check_eq("wb5_auxrdy", {31'd0, aux_ready_s}, 32'd0);
      @(posedge clk_s); #1;
      wb_valid_s = 1'b0;
      check_eq("wb5_we",    rf_we_s, 32'h0000_0020);
      check_eq("wb5_waddr", {27'd0, rf_waddr_s}, 32'd5);
      check_eq("wb5_wdata", rf_wdata_s, 32'hDEAD_BEEF);
      @(posedge clk_s); #1;
      check_eq("idle_we",    rf_we_s, 32'd0);
      check_eq("idle_waddr", {27'd0, rf_waddr_s}, 32'd5);
      check_eq("idle_wdata", rf_wdata_s, 32'hDEAD_BEEF);

      // contention: wb x3 held, aux x7 forced in its 5th cycle
      wb_valid_s = 1'b1;  wb_addr_s  = 5'd3; wb_data_s  = 32'h0000_0033;
      aux_valid_s = 1'b1; aux_addr_s = 5'd7; aux_data_s = 32'h0000_0077;
      for (int c = 1; c <= 5; c++) begin
         #1;
         check_eq("cont_wbrdy",  {31'd0, wb_ready_s},  (c < 5) ? 32'd1 : 32'd0);
         check_eq("cont_auxrdy", {31'd0, aux_ready_s}, (c < 5) ? 32'd0 : 32'd1);
         @(posedge clk_s); #1;
         check_eq("cont_we",    rf_we_s,    (c < 5) ? 32'h0000_0008 : 32'h0000_0080);
         check_eq("cont_wdata", rf_wdata_s, (c < 5) ? 32'h0000_0033 : 32'h0000_0077);
      end
      // new aux request immediately: wait counter must have restarted, so wb wins
      aux_addr_s = 5'd9; aux_data_s = 32'h0000_0099;
      #1;
      check_eq("rst_wait_wbrdy",  {31'd0, wb_ready_s},  32'd1);
      check_eq("rst_wait_auxrdy", {31'd0, aux_ready_s}, 32'd0);
      @(posedge clk_s); #1;
      check_eq("rst_wait_we", rf_we_s, 32'h0000_0008);
      wb_valid_s = 1'b0;
      #1;
      check_eq("aux9_auxrdy", {31'd0, aux_ready_s}, 32'd1);
      @(posedge clk_s); #1;
      aux_valid_s = 1'b0;
      check_eq("aux9_we",    rf_we_s, 32'h0000_0200);
      check_eq("aux9_wdata", rf_wdata_s, 32'h0000_0099);

      // aux write to x0 is accepted but does not enable any register
      aux_valid_s = 1'b1; aux_addr_s = 5'd0; aux_data_s = 32'h1234_5678;
      #1;
      check_eq("x0_auxrdy", {31'd0, aux_ready_s}, 32'd1);
      @(posedge clk_s); #1;
      aux_valid_s = 1'b0;
      check_eq("x0_we",    rf_we_s, 32'd0);
      check_eq("x0_waddr", {27'd0, rf_waddr_s}, 32'd0);
      check_eq("x0_wdata", rf_wdata_s, 32'h1234_5678);

      // reset asserted mid-operation clears outputs immediately
      wb_valid_s = 1'b1; wb_addr_s = 5'd12; wb_data_s = 32'hCAFE_F00D;
      @(posedge clk_s); #1;
      wb_valid_s = 1'b0;
      check_eq("pre_rst_we", rf_we_s, 32'h0000_1000);
      #2;
      rst_n_s = 1'b0;
      #1;
      check_zero_outputs("midop_rst");
      check_eq("midop_rst_busy", {31'd0, busy_s}, exp_busy);
      @(negedge clk_s);
      rst_n_s = 1'b1;

`ifdef RF_ARB_CLEAR_EN
      // abort the sweep in its 10th cycle, then it must restart from x1
      run_sweep(9);
      #2;
      rst_n_s = 1'b0;
      #1;
      check_zero_outputs("midsweep_rst");
      check_eq("midsweep_busy", {31'd0, busy_s}, 32'd1);
      @(negedge clk_s);
      @(negedge clk_s);
      rst_n_s = 1'b1;
      run_sweep(31);
      check_eq("resweep_busy", {31'd0, busy_s}, 32'd0);
`endif

      aux_valid_s = 1'b1; aux_addr_s = 5'd1; aux_data_s = 32'h0BAD_CAFE;
      #1;
      check_eq("final_auxrdy", {31'd0, aux_ready_s}, 32'd1);
      @(posedge clk_s); #1;
      aux_valid_s = 1'b0;
      check_eq("final_we",    rf_we_s, 32'h0000_0002);
      check_eq("final_wdata", rf_wdata_s, 32'h0BAD_CAFE);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
